uart_int_ctrl: RTL and testbench

UART_INT_CTRL -- requirements
Module: uart_int_ctrl

---
 rtl/uart_int_pkg.sv | 26 ++
 rtl/uart_int_prio_enc.sv | 23 ++
 rtl/uart_int_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_int_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_int_pkg.sv
// Shared constants for the UART interrupt controller.
// The coalescing FSM state type is only used when UART_INT_COALESCE_EN is defined.
package uart_int_pkg;

    localparam int unsigned NSRC_DEF   = 5;
    localparam int unsigned ID_W_DEF   = 3;
    localparam int unsigned HOLD_W_DEF = 8;
    localparam int unsigned IIR_W_DEF  = ID_W_DEF + 1;

    // IIR value with nothing pending: id = 0, ip_n = 1
    localparam logic [IIR_W_DEF-1:0] IIR_NONE = IIR_W_DEF'(1);

    // Source indices, lowest index wins
    localparam int unsigned SRC_RLS  = 0;
    localparam int unsigned SRC_RDA  = 1;
    localparam int unsigned SRC_TI   = 2;
    localparam int unsigned SRC_THRE = 3;
    localparam int unsigned SRC_MS   = 4;

    typedef enum logic [1:0] {
        CO_IDLE,
        CO_HOLD,
        CO_ACTIVE
    } coal_state_e;

endpackage

// File: rtl/uart_int_prio_enc.sv
// Combinational priority encoder: lowest-numbered set request wins.
module uart_int_prio_enc #(
    parameter int unsigned NSRC = 5,
    parameter int unsigned ID_W = 3
) (
    input  logic [NSRC-1:0] i_req,
    output logic [ID_W-1:0] o_id,
    output logic            o_valid
);

    // Scan from the top so the lowest set index is written last
    always_comb begin
        o_id = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = ID_W'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/uart_int_ctrl.sv
// UART interrupt controller: edge-detected pending flags, IIR priority
// encoding, and an optional interrupt coalescing hold counter selected by
// the macro UART_INT_COALESCE_EN.
module uart_int_ctrl
    import uart_int_pkg::*;
#(
    parameter int unsigned NSRC   = NSRC_DEF,
    parameter int unsigned ID_W   = ID_W_DEF,
    parameter int unsigned HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic [NSRC-1:0]   src_lvl_i,
    input  logic [NSRC-1:0]   ier_i,
    input  logic [NSRC-1:0]   clr_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic [NSRC-1:0]   pnd_o,
    output logic [ID_W:0]     iir_o,
    output logic              int_o
);

    localparam logic [ID_W:0] IIR_RST = (ID_W + 1)'(IIR_NONE);

    logic [NSRC-1:0] r_lvl_d;
    logic [NSRC-1:0] r_pnd;
    logic [ID_W:0]   r_iir;
    logic            r_int;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pnd_nxt;
    logic [ID_W-1:0] w_id;
    logic            w_valid;
    logic            w_int_nxt;

    assign w_rise    = src_lvl_i & ~r_lvl_d & ier_i;
    // Rise beats clear; otherwise a pending bit survives only while enabled
    assign w_pnd_nxt = w_rise | (~clr_i & r_pnd & ier_i);

    uart_int_prio_enc #(
        .NSRC (NSRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .i_req   (r_pnd),
        .o_id    (w_id),
        .o_valid (w_valid)
    );

    // Level history, pending flags and IIR
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_lvl_d <= '0;
            r_pnd   <= '0;
            r_iir   <= IIR_RST;
        end else begin
            r_lvl_d <= src_lvl_i;
            r_pnd   <= w_pnd_nxt;
            r_iir   <= {w_id, ~w_valid};
        end
    end

`ifdef UART_INT_COALESCE_EN
    coal_state_e       r_state;
    coal_state_e       w_state_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;

    // Coalescing state and hold counter
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= CO_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: RLS bypasses the hold, others wait out hold_i cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_pnd == '0) begin
            w_state_nxt = CO_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                CO_IDLE: begin
                    if (r_pnd[0] || (hold_i == '0)) begin
                        w_state_nxt = CO_ACTIVE;
                    end else begin
                        w_state_nxt = CO_HOLD;
                        w_cnt_nxt   = hold_i;
                    end
                end
                CO_HOLD: begin
                    if (r_pnd[0] || (r_cnt <= HOLD_W'(1))) begin
                        w_state_nxt = CO_ACTIVE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - HOLD_W'(1);
                    end
                end
                CO_ACTIVE: begin
                    w_state_nxt = CO_ACTIVE;
                end
                default: begin
                    w_state_nxt = CO_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign w_int_nxt = (w_state_nxt == CO_ACTIVE);
`else
    logic w_unused_hold;

    // hold_i has no effect in this build
    assign w_unused_hold = ^hold_i;
    assign w_int_nxt     = |r_pnd;
`endif

    // Registered interrupt request
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_int <= 1'b0;
        end else begin
            r_int <= w_int_nxt;
        end
    end

    assign pnd_o = r_pnd;
    assign iir_o = r_iir;
    assign int_o = r_int;

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Directed testbench for uart_int_ctrl; coalescing checks run when
// UART_INT_COALESCE_EN is defined.
module tb_uart_int_ctrl;

    logic       clk;
    logic       wb_rst_i;
    logic [4:0] src_lvl_i;
    logic [4:0] ier_i;
    logic [4:0] clr_i;
    logic [7:0] hold_i;
    logic [4:0] pnd_o;
    logic [3:0] iir_o;
    logic       int_o;

    int vecs;
    int miss;

    uart_int_ctrl dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .src_lvl_i (src_lvl_i),
        .ier_i     (ier_i),
        .clr_i     (clr_i),
        .hold_i    (hold_i),
        .pnd_o     (pnd_o),
        .iir_o     (iir_o),
        .int_o     (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vecs      = 0;
        miss      = 0;
        wb_rst_i  = 1'b1;
        src_lvl_i = 5'b00000;
        ier_i     = 5'b00000;
        clr_i     = 5'b00000;
        hold_i    = 8'd0;
        step();
        step();
        chk("rst_pnd", 32'(pnd_o), 32'h0);
        chk("rst_iir", 32'(iir_o), 32'h1);
        chk("rst_int", 32'(int_o), 32'h0);
        wb_rst_i = 1'b0;
        ier_i    = 5'b11111;
        step();

        // Single source RDA
        src_lvl_i = 5'b00010;
        step();
        chk("s1_pnd_e1", 32'(pnd_o), 32'h02);
        chk("s1_int_e1", 32'(int_o), 32'h0);
        chk("s1_iir_e1", 32'(iir_o), 32'h1);
        step();
        chk("s1_iir_e2", 32'(iir_o), 32'h2);
        chk("s1_int_e2", 32'(int_o), 32'h1);
        clr_i = 5'b00010;
        step();
        clr_i = 5'b00000;
        chk("s1_pnd_clr", 32'(pnd_o), 32'h00);
        chk("s1_int_clr1", 32'(int_o), 32'h1);
        step();
        chk("s1_int_clr2", 32'(int_o), 32'h0);
        chk("s1_iir_clr2", 32'(iir_o), 32'h1);
        step();
        chk("s1_no_retrig", 32'(pnd_o), 32'h00);
        src_lvl_i = 5'b00000;
        step();

        // Priority: MS and TI together, then RLS
        src_lvl_i = 5'b10100;
        step();
        chk("pr_pnd", 32'(pnd_o), 32'h14);
        step();
        chk("pr_iir_2", 32'(iir_o), 32'h4);
        chk("pr_int", 32'(int_o), 32'h1);
        src_lvl_i = 5'b10101;
        step();
        chk("pr_pnd_rls", 32'(pnd_o), 32'h15);
        step();
        chk("pr_iir_0", 32'(iir_o), 32'h0);
        clr_i = 5'b00001;
        step();
        clr_i = 5'b00000;
        step();
        chk("pr_iir_after0", 32'(iir_o), 32'h4);
        clr_i = 5'b00100;
        step();
        clr_i = 5'b00000;
        step();
        chk("pr_iir_after2", 32'(iir_o), 32'h8);
        clr_i = 5'b10000;
        step();
        clr_i = 5'b00000;
        step();
        chk("pr_int_done", 32'(int_o), 32'h0);
        chk("pr_iir_done", 32'(iir_o), 32'h1);
        src_lvl_i = 5'b00000;
        step();

        // Rise coincident with clear on THRE
        src_lvl_i = 5'b01000;
        step();
        step();
        chk("rc_int_set", 32'(int_o), 32'h1);
        src_lvl_i = 5'b00000;
        step();
        src_lvl_i = 5'b01000;
        clr_i     = 5'b01000;
        step();
        clr_i = 5'b00000;
        chk("rc_pnd_kept", 32'(pnd_o), 32'h08);
        step();
        chk("rc_int_kept", 32'(int_o), 32'h1);
        clr_i = 5'b01000;
        step();
        clr_i = 5'b00000;
        step();
        chk("rc_int_done", 32'(int_o), 32'h0);
        src_lvl_i = 5'b00000;
        step();

        // Enable drop on MS
        src_lvl_i = 5'b10000;
        step();
        step();
        chk("en_int_set", 32'(int_o), 32'h1);
        ier_i = 5'b01111;
        step();
        chk("en_pnd_drop", 32'(pnd_o), 32'h00);
        chk("en_int_lag", 32'(int_o), 32'h1);
        step();
        chk("en_int_drop", 32'(int_o), 32'h0);
        ier_i = 5'b11111;
        step();
        step();
        chk("en_no_repend", 32'(pnd_o), 32'h00);
        chk("en_int_off", 32'(int_o), 32'h0);
        src_lvl_i = 5'b00000;
        step();

        // Reset with a level held high re-pends after release
        src_lvl_i = 5'b00100;
        step();
        chk("rr_pnd_pre", 32'(pnd_o), 32'h04);
        wb_rst_i = 1'b1;
        #1;
        chk("rr_pnd_async", 32'(pnd_o), 32'h00);
        chk("rr_iir_async", 32'(iir_o), 32'h1);
        chk("rr_int_async", 32'(int_o), 32'h0);
        step();
        wb_rst_i = 1'b0;
        step();
        chk("rr_pnd_rel", 32'(pnd_o), 32'h04);
        step();
        chk("rr_int_rel", 32'(int_o), 32'h1);
        chk("rr_iir_rel", 32'(iir_o), 32'h4);
        clr_i = 5'b00100;
        step();
        clr_i     = 5'b00000;
        src_lvl_i = 5'b00000;
        step();
        step();
        chk("rr_int_done", 32'(int_o), 32'h0);

        hold_i = 8'd10;
`ifdef UART_INT_COALESCE_EN
        // RDA held off 10 extra edges
        src_lvl_i = 5'b00010;
        step();
        chk("co_pnd", 32'(pnd_o), 32'h02);
        for (int k = 2; k <= 11; k++) begin
            step();
            chk("co_int_hold", 32'(int_o), 32'h0);
        end
        step();
        chk("co_int_fire", 32'(int_o), 32'h1);
        chk("co_iir", 32'(iir_o), 32'h2);
        clr_i = 5'b00010;
        step();
        clr_i     = 5'b00000;
        src_lvl_i = 5'b00000;
        step();
        chk("co_int_done", 32'(int_o), 32'h0);
        step();

        // RLS mid-count bypasses the hold
        src_lvl_i = 5'b00010;
        step();
        step();
        step();
        step();
        src_lvl_i = 5'b00011;
        step();
        chk("cb_int_wait", 32'(int_o), 32'h0);
        step();
        chk("cb_int_fire", 32'(int_o), 32'h1);
        clr_i = 5'b00011;
        step();
        clr_i     = 5'b00000;
        src_lvl_i = 5'b00000;
        step();
        chk("cb_int_done", 32'(int_o), 32'h0);
        step();

        // Reset mid-count abandons the hold
        src_lvl_i = 5'b00010;
        step();
        step();
        step();
        wb_rst_i = 1'b1;
        #1;
        chk("cr_pnd", 32'(pnd_o), 32'h00);
        chk("cr_iir", 32'(iir_o), 32'h1);
        chk("cr_int", 32'(int_o), 32'h0);
        step();
        wb_rst_i = 1'b0;
        step();
        chk("cr_pnd_rel", 32'(pnd_o), 32'h02);
        for (int k = 2; k <= 11; k++) begin
            step();
            chk("cr_int_hold", 32'(int_o), 32'h0);
        end
        step();
        chk("cr_int_fire", 32'(int_o), 32'h1);
`else
        // hold_i has no effect without coalescing
        src_lvl_i = 5'b00010;
        step();
        chk("nc_pnd", 32'(pnd_o), 32'h02);
        step();
        chk("nc_int", 32'(int_o), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
